noise_channel_nes: RTL

NOISE_CHANNEL_NES -- requirements
Module: noise_channel_nes

---
 rtl/noise_pkg.sv | 35 +++
 rtl/envelope_unit.sv | 61 ++++++
 rtl/noise_channel_nes.sv | 128 ++++++++++++
 3 files changed

// File: rtl/noise_pkg.sv
// Shared constants for the NES-style noise channel: register map, timer period
// and length-counter lookup tables, and the packed register-file layout.
package noise_pkg;

  typedef enum logic [1:0] {
    ADDR_ENV    = 2'd0,
    ADDR_PERIOD = 2'd1,
    ADDR_LENGTH = 2'd2,
    ADDR_UNUSED = 2'd3
  } reg_addr_e;

  localparam logic [3:0] DECAY_MAX = 4'd15;

  localparam logic [11:0] PERIOD_TABLE [16] = '{
    12'd4,   12'd8,   12'd16,  12'd32,  12'd64,  12'd96,   12'd128,  12'd160,
    12'd202, 12'd254, 12'd380, 12'd508, 12'd762, 12'd1016, 12'd2034, 12'd4068
  };

  localparam logic [7:0] LENGTH_TABLE [32] = '{
    8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  typedef struct packed {
    logic       halt;       // also the envelope loop flag
    logic       const_vol;
    logic [3:0] vol;
    logic       mode;
    logic [3:0] pidx;
    logic [4:0] lidx;
  } regs_t;

endpackage

// File: rtl/envelope_unit.sv
// Decaying volume envelope (start flag, divider, decay level) clocked by the
// quarter-frame strobe; shared by any channel that needs an envelope.
module envelope_unit
  import noise_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_quarter_stb,
  input  logic       i_start_set,
  input  logic       i_loop,
  input  logic [3:0] i_period,
  output logic [3:0] o_decay
);

  logic       start_q, start_d;
  logic [3:0] divider_q, divider_d;
  logic [3:0] decay_q, decay_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    start_d   = start_q;
    divider_d = divider_q;
    decay_d   = decay_q;
    if (i_quarter_stb) begin
      if (start_q) begin
        start_d   = 1'b0;
        decay_d   = DECAY_MAX;
        divider_d = i_period;
      end else if (divider_q == 4'd0) begin
        divider_d = i_period;
        if (decay_q != 4'd0) begin
          decay_d = decay_q - 4'd1;
        end else if (i_loop) begin
          decay_d = DECAY_MAX;
        end
      end else begin
        divider_d = divider_q - 4'd1;
      end
    end
    // A fresh length write re-arms the envelope even if a quarter tick consumed the old flag.
    if (i_start_set) begin
      start_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!i_rst_n) begin
      start_q   <= 1'b0;
      divider_q <= 4'd0;
      decay_q   <= 4'd0;
    end else begin
      start_q   <= start_d;
      divider_q <= divider_d;
      decay_q   <= decay_d;
    end
  end

  assign o_decay = decay_q;

endmodule

// File: rtl/noise_channel_nes.sv
// NES-style noise channel: period timer clocking an LFSR, length counter and
// envelope, gated into a registered output sample.
module noise_channel_nes
  import noise_pkg::*;
#(
  parameter int LFSR_WIDTH   = 15,
  parameter int SHORT_TAP    = 6,
  parameter int OUT_WIDTH    = 9,
  parameter int PERIOD_WIDTH = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick_stb,
  input  logic                 i_quarter_stb,
  input  logic                 i_half_stb,
  input  logic                 i_wr_stb,
  input  logic [1:0]           i_wr_addr,
  input  logic [7:0]           i_wr_data,
  input  logic                 i_enable,
  output logic [OUT_WIDTH-1:0] o_output,
  output logic                 o_active,
  output logic                 o_shift_stb
);

  regs_t                   regs_q, regs_d;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [7:0]              length_q, length_d;
  logic [OUT_WIDTH-1:0]    output_q, output_d;
  logic                    shift_stb_q, shift_stb_d;
  logic [3:0]              env_decay;
  logic [3:0]              volume;
  logic                    len_wr;
  logic                    feedback;
  logic                    unused_wr_bit;

  assign len_wr        = i_wr_stb && (reg_addr_e'(i_wr_addr) == ADDR_LENGTH);
  assign unused_wr_bit = i_wr_data[6];

  envelope_unit u_env (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_quarter_stb (i_quarter_stb),
    .i_start_set   (len_wr),
    .i_loop        (regs_q.halt),
    .i_period      (regs_q.vol),
    .o_decay       (env_decay)
  );

  always_comb begin
    regs_d = regs_q;
    if (i_wr_stb) begin
      case (reg_addr_e'(i_wr_addr))
        ADDR_ENV: begin
          regs_d.halt      = i_wr_data[5];
          regs_d.const_vol = i_wr_data[4];
          regs_d.vol       = i_wr_data[3:0];
        end
        ADDR_PERIOD: begin
          regs_d.mode = i_wr_data[7];
          regs_d.pidx = i_wr_data[3:0];
        end
        ADDR_LENGTH: regs_d.lidx = i_wr_data[7:3];
        default: ;
      endcase
    end
  end

  // The reload uses the period index already in the register, so a pidx write
  // never disturbs a count that is in flight.
  always_comb begin
    timer_d     = timer_q;
    lfsr_d      = lfsr_q;
    shift_stb_d = 1'b0;
    feedback    = lfsr_q[0] ^ (regs_q.mode ? lfsr_q[SHORT_TAP] : lfsr_q[1]);
    if (i_tick_stb) begin
      if (timer_q == '0) begin
        timer_d     = PERIOD_WIDTH'(PERIOD_TABLE[regs_q.pidx] - 12'd1);
        lfsr_d      = {feedback, lfsr_q[LFSR_WIDTH-1:1]};
        shift_stb_d = 1'b1;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  always_comb begin
    length_d = length_q;
    if (!i_enable) begin
      length_d = '0;
    end else if (len_wr) begin
      length_d = LENGTH_TABLE[regs_d.lidx];
    end else if (i_half_stb && (length_q != 8'd0) && !regs_q.halt) begin
      length_d = length_q - 8'd1;
    end
  end

  always_comb begin
    volume   = regs_q.const_vol ? regs_q.vol : env_decay;
    output_d = '0;
    if (!lfsr_q[0] && (length_q != 8'd0)) begin
      output_d = OUT_WIDTH'(volume) << (OUT_WIDTH - 4);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      regs_q      <= '0;
      timer_q     <= '0;
      lfsr_q      <= LFSR_WIDTH'(1);
      length_q    <= '0;
      output_q    <= '0;
      shift_stb_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      timer_q     <= timer_d;
      lfsr_q      <= lfsr_d;
      length_q    <= length_d;
      output_q    <= output_d;
      shift_stb_q <= shift_stb_d;
    end
  end

  assign o_output    = output_q;
  assign o_shift_stb = shift_stb_q;
  assign o_active    = (length_q != 8'd0);

endmodule
